// File: rtl/csr_file_pkg.sv
// rtl/csr_file_pkg.sv - shared opcode, op_type and CSR address constants
package csr_file_pkg;

    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [5:0] OP_CSRRW  = 6'd40;
    localparam logic [5:0] OP_CSRRS  = 6'd41;
    localparam logic [5:0] OP_CSRRC  = 6'd42;
    localparam logic [5:0] OP_CSRRWI = 6'd43;
    localparam logic [5:0] OP_CSRRSI = 6'd44;
    localparam logic [5:0] OP_CSRRCI = 6'd45;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [31:0] MSTATUS_RST_DEFAULT = 32'h0000_1800;

    function automatic logic is_csr_op(input logic [5:0] op);
        return (op == OP_CSRRW)  || (op == OP_CSRRS)  || (op == OP_CSRRC) ||
               (op == OP_CSRRWI) || (op == OP_CSRRSI) || (op == OP_CSRRCI);
    endfunction

endpackage

// File: rtl/csr_file_alu.sv
// rtl/csr_file_alu.sv - Zicsr operand select and RW/RS/RC merge
module csr_alu
    import csr_file_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [5:0]      op_type,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [4:0]      zimm,
    output logic [XLEN-1:0] new_val
);

    logic [XLEN-1:0] src;
    logic            imm_form;

    always_comb begin
        imm_form = (op_type == OP_CSRRWI) || (op_type == OP_CSRRSI) || (op_type == OP_CSRRCI);
        src      = imm_form ? {{(XLEN-5){1'b0}}, zimm} : rs1_val;
        new_val  = old_val;
        case (op_type)
            OP_CSRRW, OP_CSRRWI: new_val = src;
            OP_CSRRS, OP_CSRRSI: new_val = old_val | src;
            OP_CSRRC, OP_CSRRCI: new_val = old_val & ~src;
            default:             new_val = old_val;
        endcase
    end

endmodule

// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR file, combinational read, edge-committed RMW
module csr_file
    import csr_file_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter logic [31:0] MSTATUS_RST = 32'h0000_1800
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [6:0]      opcode,
    input  logic [5:0]      op_type,
    input  logic [31:0]     imme,
    input  logic [XLEN-1:0] reg_data_rs1,
    output logic [XLEN-1:0] csr_rd_data
);

    logic [11:0]     addr;
    logic [4:0]      zimm;
    logic            we;
    logic [XLEN-1:0] new_val;

    logic [XLEN-1:0] mstatus;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;

    logic unused_imme;
    assign unused_imme = ^imme[31:17];

    assign addr = imme[16:5];
    assign zimm = imme[4:0];
    assign we   = (opcode == OPC_SYSTEM) && is_csr_op(op_type);

    // Read-only ID registers and unimplemented addresses all fall into default.
    always_comb begin
        csr_rd_data = '0;
        case (addr)
            CSR_MSTATUS:  csr_rd_data = mstatus;
            CSR_MTVEC:    csr_rd_data = mtvec;
            CSR_MSCRATCH: csr_rd_data = mscratch;
            CSR_MEPC:     csr_rd_data = mepc;
            CSR_MCAUSE:   csr_rd_data = mcause;
            default:      csr_rd_data = '0;
        endcase
    end

    csr_alu #(.XLEN(XLEN)) u_alu (
        .op_type (op_type),
        .old_val (csr_rd_data),
        .rs1_val (reg_data_rs1),
        .zimm    (zimm),
        .new_val (new_val)
    );

    // rstn is active-high here; it wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (rstn) begin
            mstatus  <= MSTATUS_RST[XLEN-1:0];
            mtvec    <= '0;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
        end else if (we) begin
            case (addr)
                CSR_MSTATUS:  mstatus  <= new_val;
                CSR_MTVEC:    mtvec    <= new_val;
                CSR_MSCRATCH: mscratch <= new_val;
                CSR_MEPC:     mepc     <= new_val;
                CSR_MCAUSE:   mcause   <= new_val;
                default:      ;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - scoreboard bench for csr_file against an address-map model
module tb_csr_file;

    logic        clk;
    logic        rstn;
    logic [6:0]  opcode;
    logic [5:0]  op_type;
    logic [31:0] imme;
    logic [31:0] reg_data_rs1;
    logic [31:0] csr_rd_data;

    localparam logic [6:0] SYS = 7'b1110011;

    csr_file dut (
        .clk          (clk),
        .rstn         (rstn),
        .opcode       (opcode),
        .op_type      (op_type),
        .imme         (imme),
        .reg_data_rs1 (reg_data_rs1),
        .csr_rd_data  (csr_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    logic [31:0] model [int];

    function automatic void model_reset();
        model.delete();
        model[32'h300] = 32'h0000_1800;
        model[32'h305] = 32'h0;
        model[32'h340] = 32'h0;
        model[32'h341] = 32'h0;
        model[32'h342] = 32'h0;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        int k;
        k = int'(a);
        if (model.exists(k)) return model[k];
        return 32'h0;
    endfunction

    function automatic void model_exec(input logic [6:0] opc, input logic [5:0] opt,
                                       input logic [11:0] a, input logic [4:0] z,
                                       input logic [31:0] rs1);
        logic [31:0] old, src, nv;
        int k;
        k = int'(a);
        if (opc != SYS || opt < 6'd40 || opt > 6'd45) return;
        old = model_read(a);
        src = (opt >= 6'd43) ? {27'b0, z} : rs1;
        case ((int'(opt) - 40) % 3)
            0:       nv = src;
            1:       nv = old | src;
            default: nv = old & ~src;
        endcase
        if (model.exists(k)) model[k] = nv;
    endfunction

    task automatic step(input logic rst, input logic [6:0] opc, input logic [5:0] opt,
                        input logic [11:0] a, input logic [4:0] z, input logic [31:0] rs1,
                        input bit chk, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rstn         = rst;
        opcode       = opc;
        op_type      = opt;
        imme         = {$urandom_range(0, 32767), a, z};
        reg_data_rs1 = rs1;
        if (chk) begin
            e.exp  = model_read(a);
            e.name = nm;
            exp_q.push_back(e);
        end
        if (rst) model_reset();
        else     model_exec(opc, opt, a, z, rs1);
    endtask

    task automatic rd(input logic [11:0] a, input string nm);
        step(1'b0, 7'b0, 6'd0, a, 5'd0, 32'h0, 1'b1, nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (csr_rd_data === e.exp) passed++;
            else $display("FAIL %s: csr_rd_data=%h expected=%h", e.name, csr_rd_data, e.exp);
        end
    end

    logic [11:0] addr_pool [11];

    initial begin
        rstn = 1'b0; opcode = 7'b0; op_type = 6'd0; imme = 32'h0; reg_data_rs1 = 32'h0;
        addr_pool = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                      12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h000};
        model_reset();

        step(1'b1, 7'b0, 6'd0, 12'h300, 5'd0, 32'h0, 1'b0, "reset");
        rd(12'h300, "rst_mstatus");
        rd(12'h305, "rst_mtvec");
        rd(12'h340, "rst_mscratch");
        rd(12'h341, "rst_mepc");
        rd(12'h342, "rst_mcause");
        rd(12'hF14, "rst_mhartid");
        rd(12'h7C0, "rst_unimpl");

        step(1'b0, SYS, 6'd40, 12'h305, 5'd0, 32'h8000_0100, 1'b1, "csrrw_old");
        rd(12'h305, "csrrw_new");

        step(1'b0, SYS, 6'd40, 12'h340, 5'd0, 32'h0000_00F0, 1'b1, "mscr_preload");
        step(1'b0, SYS, 6'd41, 12'h340, 5'd0, 32'h0000_000F, 1'b1, "csrrs_old");
        step(1'b0, SYS, 6'd42, 12'h340, 5'd0, 32'h0000_003C, 1'b1, "csrrc_old");
        rd(12'h340, "csrrc_new");

        step(1'b0, SYS, 6'd43, 12'h341, 5'h1F, 32'hFFFF_FFFF, 1'b1, "csrrwi");
        step(1'b0, SYS, 6'd45, 12'h341, 5'h01, 32'hFFFF_FFFF, 1'b1, "csrrci");
        step(1'b0, SYS, 6'd44, 12'h341, 5'h00, 32'hFFFF_FFFF, 1'b1, "csrrsi_zero");
        rd(12'h341, "mepc_final");

        step(1'b0, SYS, 6'd40, 12'hF14, 5'd0, 32'hDEAD_BEEF, 1'b1, "ro_write");
        rd(12'hF14, "mhartid_ro");
        step(1'b0, 7'b0110011, 6'd40, 12'h342, 5'd0, 32'h1234_5678, 1'b1, "gated_op");
        step(1'b0, SYS, 6'd46, 12'h342, 5'd3, 32'h1234_5678, 1'b1, "non_csr_op");
        rd(12'h342, "mcause_gated");

        step(1'b0, SYS, 6'd40, 12'h300, 5'd0, 32'h0000_0000, 1'b1, "mstatus_clr");
        step(1'b1, SYS, 6'd40, 12'h300, 5'd0, 32'hFFFF_FFFF, 1'b1, "rst_collide");
        rd(12'h300, "rst_collide_after");

        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic [6:0]  opc;
            r   = ($urandom_range(0, 49) == 0);
            opc = ($urandom_range(0, 9) == 0) ? 7'b0110011 : SYS;
            step(r, opc, 6'($urandom_range(38, 47)), addr_pool[$urandom_range(0, 10)],
                 5'($urandom), $urandom, 1'b1, "random");
        end
        rd(12'h300, "final_mstatus");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            total++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
